// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ack check.
// Line drivers are active-high pull-down enables for an open-collector pad.
module ps2_host_tx #(
  parameter int CLK_HOLD_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES  = 750000,
  parameter int FILTER_LEN      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int HW = $clog2(CLK_HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [HW-1:0] H_MAX = HW'(CLK_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, START, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t        state;
  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_filt, fall;
  logic [FW-1:0] f_cnt;
  logic [8:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmr;
  logic          ack;
  logic          active;

  assign active = (state == SEND) || (state == ACK) ||
                  (state == WAIT_IDLE);

  // Idle bus is high, so synchronizers and filter start at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      d_s1   <= 1'b1;
      d_s2   <= 1'b1;
      c_filt <= 1'b1;
      f_cnt  <= '0;
      fall   <= 1'b0;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
      fall <= 1'b0;
      if (c_s2 == c_filt) begin
        f_cnt <= '0;
      end else if (f_cnt == F_MAX) begin
        c_filt <= c_s2;
        f_cnt  <= '0;
        fall   <= c_filt;
      end else begin
        f_cnt <= f_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      tmr      <= '0;
      ack      <= 1'b0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            shreg    <= {~^tx_data, tx_data};
            bit_cnt  <= '0;
            hold_cnt <= '0;
            ps2c_oe  <= 1'b1;
            ps2d_oe  <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (hold_cnt == H_MAX) begin
            hold_cnt <= '0;
            ps2d_oe  <= 1'b1;
            state    <= START;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        START: begin
          if (hold_cnt == HW'(1)) begin
            ps2c_oe <= 1'b0;
            tmr     <= '0;
            state   <= SEND;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SEND: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd9) begin
              ps2d_oe <= 1'b0;
              state   <= ACK;
            end else begin
              ps2d_oe <= ~shreg[0];
              shreg   <= {1'b0, shreg[8:1]};
            end
          end
        end
        ACK: begin
          if (fall) begin
            ack   <= ~d_s2;
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (c_filt && d_s2) begin
            tx_busy  <= 1'b0;
            tx_done  <= ack;
            tx_error <= ~ack;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Watchdog on device progress; overrides any state decision above.
      if (active) begin
        if (fall) begin
          tmr <= '0;
        end else if (tmr == T_MAX) begin
          ps2c_oe  <= 1'b0;
          ps2d_oe  <= 1'b0;
          tx_busy  <= 1'b0;
          tx_done  <= 1'b0;
          tx_error <= 1'b1;
          state    <= IDLE;
        end else begin
          tmr <= tmr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with an open-collector PS/2 device model.
// Device clock period is 40 system cycles.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2c_oe, ps2d_oe;
  logic       tx_busy, tx_done, tx_error;
  wire        ps2c = dev_clk & ~ps2c_oe;
  wire        ps2d = dev_data & ~ps2d_oe;

  int  checks = 0;
  int  fails = 0;
  int  done_tot = 0;
  int  err_tot = 0;
  bit  overlap = 1'b0;
  bit  dbl = 1'b0;
  logic pd = 1'b0;
  logic pe = 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HOLD_CYCLES(20),
    .TIMEOUT_CYCLES (400),
    .FILTER_LEN     (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .ps2c    (ps2c),
    .ps2d    (ps2d),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_error(tx_error)
  );

  always @(negedge clk) begin
    if (tx_done) done_tot <= done_tot + 1;
    if (tx_error) err_tot <= err_tot + 1;
    if (tx_done && tx_error) overlap <= 1'b1;
    if ((tx_done && pd) || (tx_error && pe)) dbl <= 1'b1;
    pd <= tx_done;
    pe <= tx_error;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
  endtask

  task automatic device(input int edges, input bit give_ack,
                        output logic [10:0] frame, output int hold);
    int w;
    frame = '0;
    hold  = 0;
    w     = 0;
    while (!ps2c_oe && w < 200) begin
      cyc(1);
      w++;
    end
    check("req_seen", ps2c_oe, 1);
    if (!ps2c_oe) return;
    w = 0;
    while (ps2c_oe && w < 200) begin
      if (!ps2d_oe) hold++;
      cyc(1);
      w++;
    end
    check("clk_release", ps2c_oe, 0);
    cyc(10);
    frame[0] = ps2d;
    for (int k = 1; k <= edges; k++) begin
      dev_clk = 1'b0;
      cyc(20);
      frame[k] = ps2d;
      dev_clk = 1'b1;
      cyc(20);
    end
    if (edges == 10) begin
      dev_data = give_ack ? 1'b0 : 1'b1;
      cyc(5);
      dev_clk = 1'b0;
      cyc(20);
      dev_clk = 1'b1;
      cyc(5);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (tx_busy && w < 300) begin
      cyc(1);
      w++;
    end
    check("busy_drop", tx_busy, 0);
    cyc(2);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] frame;
    int          done;
    int          err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [10:0] fr;
    int          hold;
    int          d0, e0, n;

    vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 11'h7FE, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 11'h402, 1, 0};
    vecs[3] = '{8'hED, 1'b0, 11'h7DA, 0, 1};

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    cyc(3);
    check("rst_c_oe", ps2c_oe, 0);
    check("rst_d_oe", ps2d_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_error, 0);
    reset = 1'b0;
    cyc(5);

    for (int i = 0; i < 4; i++) begin
      d0 = done_tot;
      e0 = err_tot;
      send_start(vecs[i].data);
      device(10, vecs[i].ack, fr, hold);
      wait_idle();
      if (i == 0) check("req_hold", hold, 20);
      check("frame", fr, vecs[i].frame);
      check("done_cnt", done_tot - d0, vecs[i].done);
      check("err_cnt", err_tot - e0, vecs[i].err);
      check("idle_c_oe", ps2c_oe, 0);
      check("idle_d_oe", ps2d_oe, 0);
    end

    // Second start while busy must not disturb the first byte.
    d0 = done_tot;
    e0 = err_tot;
    send_start(8'hED);
    cyc(3);
    send_start(8'h00);
    device(10, 1'b1, fr, hold);
    wait_idle();
    check("ign_frame", fr, 11'h7DA);
    check("ign_done", done_tot - d0, 1);
    check("ign_err", err_tot - e0, 0);
    cyc(50);
    check("ign_no_second", tx_busy, 0);

    // Device stops after 4 falling edges.
    d0 = done_tot;
    e0 = err_tot;
    send_start(8'hA5);
    device(4, 1'b1, fr, hold);
    check("to_frame", fr[4:0], 5'h0A);
    n = 0;
    while (!tx_error && n < 600) begin
      cyc(1);
      n++;
    end
    check("to_pulse", tx_error, 1);
    check("to_latency_ok", ((n + 40) >= 400) && ((n + 40) <= 410), 1);
    check("to_c_oe", ps2c_oe, 0);
    check("to_d_oe", ps2d_oe, 0);
    check("to_busy", tx_busy, 0);
    cyc(3);
    check("to_err_cnt", err_tot - e0, 1);
    check("to_done_cnt", done_tot - d0, 0);

    // Reset in the middle of SEND.
    d0 = done_tot;
    e0 = err_tot;
    send_start(8'h3C);
    device(3, 1'b1, fr, hold);
    check("rs_in_send", tx_busy, 1);
    reset = 1'b1;
    cyc(1);
    check("rs_c_oe", ps2c_oe, 0);
    check("rs_d_oe", ps2d_oe, 0);
    check("rs_busy", tx_busy, 0);
    reset = 1'b0;
    cyc(5);
    check("rs_done_cnt", done_tot - d0, 0);
    check("rs_err_cnt", err_tot - e0, 0);
    send_start(8'h00);
    device(10, 1'b1, fr, hold);
    wait_idle();
    check("rs_frame", fr, 11'h600);
    check("rs_after_done", done_tot - d0, 1);
    check("rs_after_err", err_tot - e0, 0);

    check("no_overlap", overlap, 0);
    check("no_double", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter CLK_HOLD_CYCLES, default 5000, giving the number of cycles the host holds PS/2 clock low for request-to-send (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 750000, the maximum number of cycles without device progress before abort (15 ms).
REQ-003 The block SHALL have parameter FILTER_LEN, default 8, the number of consecutive equal samples needed to accept a new ps2c level.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  command byte to send to the device.
REQ-007 tx_start  input  1  one-cycle request to send tx_data.
REQ-008 ps2c  input  1  sampled PS/2 clock line (asynchronous).
REQ-009 ps2d  input  1  sampled PS/2 data line (asynchronous).
REQ-010 ps2c_oe  output  1  1 = pull clock line low; 0 = release it. The top level builds the open-collector connection.
REQ-011 ps2d_oe  output  1  1 = pull data line low; 0 = release it.
REQ-012 tx_busy  output  1  high in every state except IDLE.
REQ-013 tx_done  output  1  one-cycle pulse when the device acknowledges.
REQ-014 tx_error  output  1  one-cycle pulse on missing acknowledge or timeout.

Function
REQ-015 The block SHALL pass ps2c and ps2d through 2-flop synchronizers.
REQ-016 Filtered clock level SHALL change only after FILTER_LEN consecutive equal synchronized samples.
REQ-017 A falling edge SHALL be a 1-to-0 change of the filtered clock, flagged for exactly one cycle.
REQ-018 States SHALL be IDLE, REQ, START, SEND, ACK, WAIT_IDLE.
REQ-019 IDLE:
- tx_start=1 latches tx_data, computes the odd parity bit, and enters REQ on the next cycle.
- tx_start while not IDLE SHALL be ignored.
REQ-020 REQ: ps2c_oe=1 and ps2d_oe=0 for exactly CLK_HOLD_CYCLES cycles, then enter START.
REQ-021 START: ps2c_oe=1 and ps2d_oe=1 (start bit) for 2 cycles, then enter SEND with ps2c_oe=0.
REQ-022 SEND: ps2d_oe SHALL be held at its value until a falling edge, then updated in the cycle after the edge.
- Falling edges 1-8 drive data bits 0-7, LSB first, with ps2d_oe = ~bit.
- Falling edge 9 drives parity.
- Falling edge 10 releases data (stop bit); then enter ACK.
REQ-023 Parity SHALL be odd: parity = ~^tx_data (XNOR reduction of the byte), so the data byte plus parity bit contains an odd number of ones.
REQ-024 ACK: on the next falling edge, the filtered/synchronized ps2d is sampled.
- 0 means acknowledged: enter WAIT_IDLE with the ack flag set.
- 1 means NACK: enter WAIT_IDLE with the ack flag cleared.
REQ-025 WAIT_IDLE: when filtered ps2c=1 and synchronized ps2d=1, return to IDLE.
- Ack flag set: pulse tx_done in the transition cycle.
- Ack flag clear: pulse tx_error in the transition cycle.
REQ-026 A timeout counter SHALL reset on every falling edge and on entry to SEND.
- In SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES pulses tx_error, releases both lines, and returns to IDLE.
REQ-027 ps2c_oe and ps2d_oe SHALL both be 0 in IDLE, ACK and WAIT_IDLE.
REQ-028 tx_done and tx_error SHALL never be asserted in the same cycle, and neither SHALL be asserted for more than one cycle.
REQ-029 The bit counter SHALL be 4 bits wide and the timeout counter wide enough for TIMEOUT_CYCLES, with no wrap-around in normal operation.

Reset
REQ-030 Reset SHALL force state IDLE and clear ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_error, all counters, the shift register and the filters; the filtered clock level resets to 1.
REQ-031 Reset asserted mid-transfer SHALL release both lines on the next clock edge with no tx_done or tx_error pulse.

Verification
Simulation parameters: CLK_HOLD_CYCLES=20, TIMEOUT_CYCLES=400, FILTER_LEN=2; a device model clocks at 40-cycle period.
REQ-032 tx_data=0xED, tx_start pulse:
- ps2c_oe high for 20 cycles.
- Device samples start 0, then bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
- Device acks 0, and tx_done pulses once.
REQ-033 tx_data=0xFF gives parity 1 and tx_data=0x01 gives parity 0; the device sees the correct bits and tx_done pulses.
REQ-034 Device model gives no ack (data stays 1 on the 11th falling edge) -> tx_error pulses once and tx_done stays 0.
REQ-035 Device stops clocking after the 4th falling edge -> tx_error pulses 400 cycles after the last edge, both oe are 0, and the state is IDLE.
REQ-036 Second tx_start while busy -> ignored, and only the first byte is sent.
REQ-037 Reset during SEND -> next cycle both oe=0 and tx_busy=0 with no pulses; a following tx_start with 0x00 completes with tx_done.
